// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: register control codes, ALU codes,
// opcodes and the control-unit state encoding.
package cpu_pkg;

    localparam logic [3:0] RegClear = 4'd0;
    localparam logic [3:0] RegLoad  = 4'd1;
    localparam logic [3:0] RegHold  = 4'd2;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;

    localparam logic [3:0] OpNop    = 4'd0;
    localparam logic [3:0] OpLdx    = 4'd1;
    localparam logic [3:0] OpLdy    = 4'd2;
    localparam logic [3:0] OpAdd    = 4'd3;
    localparam logic [3:0] OpSub    = 4'd4;
    localparam logic [3:0] OpAnd    = 4'd5;
    localparam logic [3:0] OpOr     = 4'd6;
    localparam logic [3:0] OpClrz   = 4'd7;
    localparam logic [3:0] OpClrall = 4'd8;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAct,
        StExec,
        StWb
    } state_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: ALU/one-cycle class, register codes for the
// one-cycle case, ALU operation and illegal-opcode flag.
module op_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_is_alu,
    output logic       o_illegal,
    output logic [3:0] o_tx,
    output logic [3:0] o_ty,
    output logic [3:0] o_tz,
    output logic [3:0] o_tula
);

    always_comb begin
        o_is_alu  = 1'b0;
        o_illegal = 1'b0;
        o_tx      = RegHold;
        o_ty      = RegHold;
        o_tz      = RegHold;
        o_tula    = AluAdd;
        case (i_opcode)
            OpNop: ;
            OpLdx: o_tx = RegLoad;
            OpLdy: o_ty = RegLoad;
            OpAdd: begin
                o_is_alu = 1'b1;
                o_tula   = AluAdd;
            end
            OpSub: begin
                o_is_alu = 1'b1;
                o_tula   = AluSub;
            end
            OpAnd: begin
                o_is_alu = 1'b1;
                o_tula   = AluAnd;
            end
            OpOr: begin
                o_is_alu = 1'b1;
                o_tula   = AluOr;
            end
            OpClrz: o_tz = RegClear;
            OpClrall: begin
                o_tx = RegClear;
                o_ty = RegClear;
                o_tz = RegClear;
            end
            // Illegal opcodes behave as NOP apart from raising the flag.
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Control unit: accepts one opcode per handshake and sequences the X/Y/Z register
// codes and ALU operation; counts retired instructions and flags illegal opcodes.
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       opcode,
    output logic             instr_ready,
    output logic [3:0]       tx,
    output logic [3:0]       ty,
    output logic [3:0]       tz,
    output logic [3:0]       tula,
    output logic             done,
    output logic             erro,
    output logic [CNT_W-1:0] contador
);

    state_t r_state, w_state_d;

    logic [3:0]       r_opcode, w_op_sel;
    logic             w_handshake;
    logic             w_is_alu, w_illegal;
    logic [3:0]       w_dec_tx, w_dec_ty, w_dec_tz, w_dec_tula;

    logic [3:0]       r_tx, r_ty, r_tz, r_tula;
    logic [3:0]       w_tx_d, w_ty_d, w_tz_d, w_tula_d;
    logic             r_done, w_done_d;
    logic             r_ready, w_ready_d;
    logic             r_erro, w_erro_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    assign w_handshake = instr_valid & r_ready;
    // Decode the incoming opcode on the handshake edge, the latched one afterwards.
    assign w_op_sel    = w_handshake ? opcode : r_opcode;

    op_decoder u_op_decoder (
        .i_opcode  (w_op_sel),
        .o_is_alu  (w_is_alu),
        .o_illegal (w_illegal),
        .o_tx      (w_dec_tx),
        .o_ty      (w_dec_ty),
        .o_tz      (w_dec_tz),
        .o_tula    (w_dec_tula)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StInit: w_state_d = StIdle;
            StIdle: if (w_handshake) w_state_d = w_is_alu ? StExec : StAct;
            StAct:  w_state_d = StIdle;
            StExec: w_state_d = StWb;
            StWb:   w_state_d = StIdle;
            default: w_state_d = StInit;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        w_tx_d    = RegHold;
        w_ty_d    = RegHold;
        w_tz_d    = RegHold;
        w_tula_d  = AluAdd;
        w_done_d  = 1'b0;
        w_ready_d = 1'b0;
        w_erro_d  = r_erro;
        w_cnt_d   = r_cnt;
        case (w_state_d)
            StIdle: w_ready_d = 1'b1;
            StAct: begin
                w_tx_d   = w_dec_tx;
                w_ty_d   = w_dec_ty;
                w_tz_d   = w_dec_tz;
                w_done_d = 1'b1;
                if (w_illegal) w_erro_d = 1'b1;
            end
            StExec: w_tula_d = w_dec_tula;
            StWb: begin
                w_tula_d = w_dec_tula;
                w_tz_d   = RegLoad;
                w_done_d = 1'b1;
            end
            default: begin
                w_tx_d = RegClear;
                w_ty_d = RegClear;
                w_tz_d = RegClear;
            end
        endcase
        if (w_done_d) w_cnt_d = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StInit;
            r_opcode <= OpNop;
            r_tx     <= RegClear;
            r_ty     <= RegClear;
            r_tz     <= RegClear;
            r_tula   <= AluAdd;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
            r_erro   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_opcode <= w_op_sel;
            r_tx     <= w_tx_d;
            r_ty     <= w_ty_d;
            r_tz     <= w_tz_d;
            r_tula   <= w_tula_d;
            r_done   <= w_done_d;
            r_ready  <= w_ready_d;
            r_erro   <= w_erro_d;
            r_cnt    <= w_cnt_d;
        end
    end

    assign instr_ready = r_ready;
    assign tx          = r_tx;
    assign ty          = r_ty;
    assign tz          = r_tz;
    assign tula        = r_tula;
    assign done        = r_done;
    assign erro        = r_erro;
    assign contador    = r_cnt;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: schedule-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = 4'd0;

    logic       instr_ready, done, erro;
    logic [3:0] tx, ty, tz, tula;
    logic [7:0] contador;

    logic       d2_ready, d2_done, d2_erro;
    logic [3:0] d2_tx, d2_ty, d2_tz, d2_tula;
    logic [1:0] d2_contador;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    unidade_controle #(.CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .instr_ready (instr_ready),
        .tx          (tx),
        .ty          (ty),
        .tz          (tz),
        .tula        (tula),
        .done        (done),
        .erro        (erro),
        .contador    (contador)
    );

    unidade_controle #(.CNT_W(2)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .instr_ready (d2_ready),
        .tx          (d2_tx),
        .ty          (d2_ty),
        .tz          (d2_tz),
        .tula        (d2_tula),
        .done        (d2_done),
        .erro        (d2_erro),
        .contador    (d2_contador)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted opcode appends its per-cycle output tuples.
    typedef struct packed {
        logic [3:0] tx, ty, tz, tula;
        logic       done, ready, chk_tula;
    } exp_t;

    function automatic exp_t mk(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                                input logic [3:0] u, input logic d, input logic r,
                                input logic c);
        exp_t e;
        e.tx = x; e.ty = y; e.tz = z; e.tula = u;
        e.done = d; e.ready = r; e.chk_tula = c;
        return e;
    endfunction

    exp_t m_exp;
    exp_t m_q[$];
    logic m_valid = 1'b0;
    logic m_accepted = 1'b0;
    logic m_err = 1'b0;
    int   m_cnt = 0;

    always @(posedge clock) begin
        m_accepted = 1'b0;
        if (reset) begin
            m_q.delete();
            m_exp   = mk(0, 0, 0, 0, 0, 0, 1);
            m_cnt   = 0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_exp.ready && instr_valid) begin
                int op;
                op = int'(opcode);
                m_accepted = 1'b1;
                if (op >= 3 && op <= 6) begin
                    m_q.push_back(mk(2, 2, 2, 4'(op - 3), 0, 0, 1));
                    m_q.push_back(mk(2, 2, 1, 4'(op - 3), 1, 0, 1));
                end else begin
                    m_q.push_back(mk((op == 1) ? 4'd1 : (op == 8) ? 4'd0 : 4'd2,
                                     (op == 2) ? 4'd1 : (op == 8) ? 4'd0 : 4'd2,
                                     (op == 7 || op == 8) ? 4'd0 : 4'd2,
                                     0, 1, 0, 0));
                    if (op > 8) m_err = 1'b1;
                end
            end
            if (m_q.size() > 0) m_exp = m_q.pop_front();
            else m_exp = mk(2, 2, 2, 0, 0, 1, 1);
            if (m_exp.done) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("tx", tx, m_exp.tx);
            check("ty", ty, m_exp.ty);
            check("tz", tz, m_exp.tz);
            if (m_exp.chk_tula) check("tula", tula, m_exp.tula);
            check("done", done, m_exp.done);
            check("instr_ready", instr_ready, m_exp.ready);
            check("erro", erro, m_err);
            check("contador", contador, m_cnt & 255);
            check("contador_w2", d2_contador, m_cnt & 3);
            check("done_w2", d2_done, m_exp.done);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int   nop_vals[5];
    int   nop_n;
    logic pending;

    initial begin
        // Reset release
        reset = 1'b1;
        step();
        check("rst_tx", tx, 0);
        check("rst_tz", tz, 0);
        check("rst_ready", instr_ready, 0);
        check("rst_contador", contador, 0);
        check("rst_erro", erro, 0);
        reset = 1'b0;
        step();
        check("idle_tx", tx, 2);
        check("idle_ready", instr_ready, 1);

        // LDX
        instr_valid = 1'b1; opcode = 4'd1;
        step();
        instr_valid = 1'b0;
        check("ldx_tx", tx, 1);
        check("ldx_ty", ty, 2);
        check("ldx_done", done, 1);
        check("ldx_contador", contador, 1);
        step();
        check("ldx_ready_after", instr_ready, 1);

        // SUB with opcode change during EXEC
        instr_valid = 1'b1; opcode = 4'd4;
        step();
        instr_valid = 1'b0; opcode = 4'd8;
        check("sub_exec_tula", tula, 1);
        check("sub_exec_tz", tz, 2);
        check("sub_exec_done", done, 0);
        step();
        check("sub_wb_tula", tula, 1);
        check("sub_wb_tz", tz, 1);
        check("sub_wb_done", done, 1);
        check("sub_contador", contador, 2);
        step();
        check("sub_idle_ready", instr_ready, 1);

        // Illegal opcode, then ADD
        instr_valid = 1'b1; opcode = 4'd12;
        step();
        instr_valid = 1'b0;
        check("ill_tx", tx, 2);
        check("ill_done", done, 1);
        check("ill_erro", erro, 1);
        check("ill_contador", contador, 3);
        step();
        instr_valid = 1'b1; opcode = 4'd3;
        step();
        instr_valid = 1'b0;
        step();
        check("add_wb_tz", tz, 1);
        check("add_erro_sticky", erro, 1);
        check("add_contador", contador, 4);
        step();

        // Reset during EXEC of an ADD
        instr_valid = 1'b1; opcode = 4'd3;
        step();
        instr_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_tz", tz, 0);
        check("abort_done", done, 0);
        check("abort_contador", contador, 0);
        step();
        check("abort_idle_tz", tz, 2);
        check("abort_idle_done", done, 0);

        // Five back-to-back NOPs on the 2-bit counter
        instr_valid = 1'b1; opcode = 4'd0;
        nop_n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 9) instr_valid = 1'b0;
            if (d2_done === 1'b1) begin
                if (nop_n < 5) nop_vals[nop_n] = int'(d2_contador);
                nop_n++;
            end
        end
        check("nop_pulses", nop_n, 5);
        if (nop_n >= 5) begin
            check("nop_cnt0", nop_vals[0], 1);
            check("nop_cnt1", nop_vals[1], 2);
            check("nop_cnt2", nop_vals[2], 3);
            check("nop_cnt3", nop_vals[3], 0);
            check("nop_cnt4", nop_vals[4], 1);
        end
        step();

        // Reset wins over a simultaneous handshake
        instr_valid = 1'b1; opcode = 4'd1; reset = 1'b1;
        step();
        check("rstprio_tx", tx, 0);
        check("rstprio_done", done, 0);
        reset = 1'b0; instr_valid = 1'b0;
        step();

        // Randomized traffic, requester holds each request until accepted
        pending = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_accepted) pending = 1'b0;
            reset = ($urandom_range(0, 99) == 0);
            if (reset) begin
                pending = 1'b0;
                instr_valid = 1'b0;
            end else if (!pending) begin
                instr_valid = ($urandom_range(0, 2) != 0);
                opcode = 4'($urandom);
                pending = instr_valid;
            end
            step();
        end
        reset = 1'b0; instr_valid = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
